// File: rtl/frog_chip.sv
// N-cell elementary cellular automaton with Wolfram rule encoding; cell 0 streams out serially.
// Optional build macro FROG_CA_WRAP_EN selects a circular boundary instead of the default null boundary.
module frog_chip #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [7:0]   rule_num,
    input  logic [N-1:0] seed,
    input  logic         enable,
    output logic         out
);

    logic [7:0]   rule;
    logic [N-1:0] state;

    // Whole generation is computed from the old array, so no cell sees a partial update.
    function automatic logic [N-1:0] next_gen(input logic [7:0] r, input logic [N-1:0] s);
        logic [N+1:0] ext;
        logic [N-1:0] nxt;
`ifdef FROG_CA_WRAP_EN
        ext = {s[0], s, s[N-1]};
`else
        ext = {1'b0, s, 1'b0};
`endif
        nxt = '0;
        for (int i = 0; i < N; i++) begin
            nxt[i] = r[{ext[i+2], ext[i+1], ext[i]}];
        end
        return nxt;
    endfunction

    // Port rst_n is active-high despite its name.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            rule  <= '0;
            state <= '0;
        end else if (load) begin
            rule  <= rule_num;
            state <= seed;
        end else if (enable) begin
            state <= next_gen(rule, state);
        end
    end

    assign out = state[0];

endmodule

// File: tb/tb_frog_chip.sv
// Directed self-checking bench for frog_chip (N = 8) covering both boundary builds.
module tb_frog_chip;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       load;
    logic [7:0] rule_num;
    logic [7:0] seed;
    logic       enable;
    logic       out;

    int checks = 0;
    int errors = 0;

    frog_chip #(.N(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .rule_num (rule_num),
        .seed     (seed),
        .enable   (enable),
        .out      (out)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    logic [7:0] null_tail [6] = '{8'h15, 8'h0A, 8'h05, 8'h02, 8'h01, 8'h00};

    initial begin
        rst_n = 1'b1; load = 1'b0; rule_num = 8'h00; seed = 8'h00; enable = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        check("reset_out", {7'd0, out}, 8'h00);
        check("reset_state", dut.state, 8'h00);
        check("reset_rule", dut.rule, 8'h00);

        // Rule 184 from 0xAA
        rule_num = 8'hB8; seed = 8'hAA; load = 1'b1;
        step();
        load = 1'b0; rule_num = 8'h00; seed = 8'hFF;
        check("load_out", {7'd0, out}, 8'h00);
        check("load_state", dut.state, 8'hAA);
        check("load_rule", dut.rule, 8'hB8);
        enable = 1'b1;
        step();
        check("gen1_state", dut.state, 8'h55);
        check("gen1_out", {7'd0, out}, 8'h01);
        step();
`ifdef FROG_CA_WRAP_EN
        check("gen2_wrap", dut.state, 8'hAA);
        for (int k = 3; k <= 260; k++) begin
            step();
            check("wrap_toggle_out", {7'd0, out}, (k % 2 == 1) ? 8'h01 : 8'h00);
        end
        check("wrap_final_state", dut.state, 8'hAA);
`else
        check("gen2_null", dut.state, 8'h2A);
        for (int k = 0; k < 6; k++) begin
            step();
            check("null_tail_state", dut.state, null_tail[k]);
            check("null_tail_out", {7'd0, out}, {7'd0, null_tail[k][0]});
        end
`endif

        // Load wins over enable
        rule_num = 8'hCC; seed = 8'h3C; load = 1'b1; enable = 1'b1;
        step();
        load = 1'b0; seed = 8'h81;
        check("prio_state", dut.state, 8'h3C);
        for (int k = 0; k < 3; k++) begin
            step();
            check("identity_state", dut.state, 8'h3C);
        end

        // Extreme rules
        enable = 1'b0; rule_num = 8'h00; seed = 8'hFF; load = 1'b1;
        step();
        load = 1'b0; enable = 1'b1;
        step();
        check("rule0_state", dut.state, 8'h00);
        check("rule0_out", {7'd0, out}, 8'h00);
        enable = 1'b0; rule_num = 8'hFF; seed = 8'h00; load = 1'b1;
        step();
        load = 1'b0; enable = 1'b1;
        step();
        check("rule255_state", dut.state, 8'hFF);
        check("rule255_out", {7'd0, out}, 8'h01);

        // Hold with enable low
        enable = 1'b0; rule_num = 8'hB8; seed = 8'hAA; load = 1'b1;
        step();
        load = 1'b0; seed = 8'h00;
        for (int k = 0; k < 10; k++) begin
            step();
            check("hold_state", dut.state, 8'hAA);
            check("hold_out", {7'd0, out}, 8'h00);
        end

        // Reset during stepping, also overriding a load
        enable = 1'b1;
        step();
        check("pre_reset_state", dut.state, 8'h55);
        rst_n = 1'b1; load = 1'b1; rule_num = 8'hFF; seed = 8'hFF;
        step();
        rst_n = 1'b0; load = 1'b0;
        check("midreset_state", dut.state, 8'h00);
        check("midreset_out", {7'd0, out}, 8'h00);
        check("midreset_rule", dut.rule, 8'h00);
        for (int k = 0; k < 3; k++) begin
            step();
            check("post_reset_state", dut.state, 8'h00);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
